m_spi_fifo_tx: RTL and testbench
================================

// Module: m_spi_fifo_tx
// PURPOSE
//  Parametrised buffered SPI transmitter; next generation of the display SPI sender.
//  Adds a valid/ready FIFO front end, a programmable SCL divider, word width and idle polarity.
//  Adds a per-word DC flag, chip select and inter-word gap.
//  Sits between the ST7789 command/pixel sequencer and the panel pins, so the sequencer pushes words without polling busy.
// PARAMETERS
//  DATA_W      8   bits per SPI word, MSB first (>=2)
//  FIFO_DEPTH  16  FIFO entries {dc,data}; power of 2, >=2
//  CLK_DIV     1   w_clk cycles per SCL half-period (>=1)
//  CPOL        1   SCL idle level; 1 = ST7789 mode (idle high, sampled on rising edge)
//  GAP         1   idle w_clk cycles after each word, SCL idle, CS held low (>=0)
// PORTS
//  w_clk      in   1                   main clock (100MHz)
//  w_rst_n    in   1                   reset, asynchronous, active-low
//  i_valid    in   1                   push request
//  o_ready    out  1                   FIFO can accept; push occurs when i_valid && o_ready
//  i_data     in   DATA_W              word to send
//  i_dc       in   1                   DC level for this word (0=command, 1=data)
//  o_sda      out  1                   serial data
//  o_scl      out  1                   serial clock
//  o_dc       out  1                   data/command pin
//  o_cs_n     out  1                   chip select, low during a burst
//  o_busy     out  1                   FIFO non-empty or FSM not IDLE
//  o_level    out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Clocking and reset
//  - One clock; reset is asynchronous and active-low.
//  - Reset values, applied immediately while w_rst_n=0, including mid-word:
//    o_sda=1, o_scl=CPOL, o_dc=0, o_cs_n=1, o_busy=0, o_level=0, o_ready=0, FSM=IDLE, FIFO emptied.
//  - o_ready=1 from the first clock after reset release while not full.
//  - Mid-word reset aborts the word; no partial word resumes.
//  FIFO
//  - o_ready = (o_level != FIFO_DEPTH); no same-cycle full bypass.
//  - Push and pop in the same cycle leave the level unchanged.
//  - A pop never occurs when empty.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - o_level is registered; it updates the cycle after a push or pop.
//  FSM states
//  - IDLE: o_cs_n=1, o_scl=CPOL.
//    If level>0: pop, load shifter, o_dc<=entry dc, o_sda<=data MSB, o_cs_n<=0, go SHIFT.
//  - SHIFT: each bit lasts 2*CLK_DIV cycles.
//    - Phase A (CLK_DIV cycles): o_scl=~CPOL.
//    - Phase B (CLK_DIV cycles): o_scl=CPOL; the slave samples on the A->B edge.
//    - o_sda changes only at the start of phase A.
//    - After the last phase B of bit 0: if GAP>0 go GAP.
//      If GAP=0 and level>0, pop and start the next word's phase A on the next cycle (back-to-back).
//      Otherwise go IDLE.
//  - GAP: GAP cycles, o_scl=CPOL, o_sda and o_dc held, o_cs_n=0.
//    Then load the next word if level>0, else go IDLE (o_cs_n=1).
//  Latency and timing
//  - Push into an empty idle block at cycle t: pop at t+1; o_cs_n/o_dc/o_sda valid and first phase A at t+2.
//  - Word duration is 2*CLK_DIV*DATA_W cycles, plus GAP.
//  - o_dc changes only at word load, never inside a word.
// TESTING
//  1. DATA_W=8, CLK_DIV=1, CPOL=1, GAP=1; push 0xA5, dc=1.
//     -> exactly 8 rising SCL edges sampling 1,0,1,0,0,1,0,1; o_dc=1.
//     -> o_cs_n low for 17 cycles; o_busy falls after the word; o_level returns to 0.
//  2. GAP=0; push 0x2A (dc=0), then 0x00 (dc=1).
//     -> 16 continuous SCL pulses with no idle cycle; o_dc toggles 0->1 at the word boundary.
//  3. CLK_DIV=4; hold i_valid=1.
//     -> o_ready drops when o_level=16; exactly 17 words accepted before the first word ends.
//     -> all 17 words emerge in push order.
//  4. Assert w_rst_n=0 at bit 3 of a word with 5 words queued.
//     -> o_cs_n=1, o_scl=CPOL and o_level=0 before the next clock edge.
//     -> after release, no SCL activity until a new push.
//  5. CPOL=0, DATA_W=9; push 0x1FF.
//     -> SCL idle low; 9 falling edges, each sampling 1.
//  6. Push with i_valid=1 while full.
//     -> no push; the data is not corrupted; the level stays 16 until a pop.

Source files
------------

// File: rtl/m_spi_fifo_tx.sv
// Buffered SPI transmitter: valid/ready FIFO of {dc,data} words feeding an MSB-first
// shifter with programmable SCL divider, idle polarity, chip select and inter-word gap.
module m_spi_fifo_tx #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 1,
   parameter bit CPOL       = 1'b1,
   parameter int GAP        = 1
) (
   input  logic                          w_clk,
   input  logic                          w_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_dc,
   output logic                          o_sda,
   output logic                          o_scl,
   output logic                          o_dc,
   output logic                          o_cs_n,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int LVL_W      = PTR_W + 1;
   localparam int ENT_W      = DATA_W + 1;
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W      = $clog2(DATA_W);
   localparam int GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;

   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [ENT_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    level;
   logic                ready_en;
   logic                push;
   logic                pop;
   logic                go_idle;
   logic                have_word;
   logic [ENT_W-1:0]    rd_entry;

   logic [DATA_W-1:0]   shreg;
   logic [DIV_W-1:0]    div_cnt;
   logic                phase_b;
   logic [BIT_W-1:0]    bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;
   logic                div_done;
   logic                word_end;

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   assign o_ready   = ready_en && (level != LVL_FULL);
   assign push      = i_valid && o_ready;
   assign have_word = (level != '0);
   assign rd_entry  = mem[rd_ptr];
   assign o_level   = level;

   // NOTE: storage is deliberately not reset; pointers and level alone define which entries are valid.
   always_ff @(posedge w_clk) begin
      if (push) begin
         mem[wr_ptr] <= {i_dc, i_data};
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   assign div_done = (div_cnt == DIV_LAST);
   assign word_end = phase_b && div_done && (bit_cnt == '0);
   assign o_busy   = have_word || (state != S_IDLE);

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block is given a default first so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      go_idle    = 1'b0;
      case (state)
         S_IDLE: begin
            if (have_word) begin
               pop        = 1'b1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (word_end) begin
               if (GAP > 0) begin
                  state_next = S_GAP;
               end else if (have_word) begin
                  pop = 1'b1;
               end else begin
                  go_idle    = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (have_word) begin
                  pop        = 1'b1;
                  state_next = S_SHIFT;
               end else begin
                  go_idle    = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shifter and pin registers
   // ------------------------------------------------------------------
   // The current bit always sits in the shifter MSB; ones are shifted in so SDA idles high.
   assign o_sda = shreg[DATA_W-1];

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         shreg   <= '1;
         o_scl   <= CPOL;
         o_dc    <= 1'b0;
         o_cs_n  <= 1'b1;
         div_cnt <= '0;
         phase_b <= 1'b0;
         bit_cnt <= '0;
         gap_cnt <= '0;
      end else if (pop) begin
         shreg   <= rd_entry[DATA_W-1:0];
         o_dc    <= rd_entry[DATA_W];
         o_cs_n  <= 1'b0;
         o_scl   <= ~CPOL;
         div_cnt <= '0;
         phase_b <= 1'b0;
         bit_cnt <= BIT_LAST;
      end else if (go_idle) begin
         o_cs_n  <= 1'b1;
         o_scl   <= CPOL;
      end else if (state == S_SHIFT) begin
         if (div_done) begin
            div_cnt <= '0;
            if (!phase_b) begin
               phase_b <= 1'b1;
               o_scl   <= CPOL;
            end else if (bit_cnt != '0) begin
               bit_cnt <= bit_cnt - BIT_W'(1);
               shreg   <= {shreg[DATA_W-2:0], 1'b1};
               phase_b <= 1'b0;
               o_scl   <= ~CPOL;
            end else begin
               gap_cnt <= '0;
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end else if (state == S_GAP) begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

endmodule

// File: tb/tb_m_spi_fifo_tx.sv
// Bench for m_spi_fifo_tx: three configurations share one clock and reset; an SPI
// monitor rebuilds each word on the sampling edge and compares it to a scoreboard.
module tb_m_spi_fifo_tx;

   typedef struct packed {
      logic [1:0] dut;
      logic       dc;
      logic [8:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] valid;
   logic [8:0] data;
   logic       dc_in;
   logic [2:0] ready, sda, scl, dc_out, cs_n, busy;
   logic [4:0] level [3];

   exp_t       exp_q [$];
   exp_t       mon_e;
   logic [2:0] prev_scl;
   logic [8:0] mon_sh [3];
   logic [2:0] mon_dc0;
   int         mon_bits [3];
   int         words_done [3];
   int         edge_cnt [3];

   int         n_vec = 0;
   int         n_miss = 0;

   always #5 clk = ~clk;

   // dut 0: 8 bit, div 1, CPOL 1, gap 1
   m_spi_fifo_tx #(.DATA_W(8), .FIFO_DEPTH(16), .CLK_DIV(1), .CPOL(1'b1), .GAP(1)) u_dut0 (
      .w_clk(clk), .w_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]),
      .i_data(data[7:0]), .i_dc(dc_in), .o_sda(sda[0]), .o_scl(scl[0]), .o_dc(dc_out[0]),
      .o_cs_n(cs_n[0]), .o_busy(busy[0]), .o_level(level[0]));

   // dut 1: 8 bit, div 4, CPOL 1, no gap
   m_spi_fifo_tx #(.DATA_W(8), .FIFO_DEPTH(16), .CLK_DIV(4), .CPOL(1'b1), .GAP(0)) u_dut1 (
      .w_clk(clk), .w_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]),
      .i_data(data[7:0]), .i_dc(dc_in), .o_sda(sda[1]), .o_scl(scl[1]), .o_dc(dc_out[1]),
      .o_cs_n(cs_n[1]), .o_busy(busy[1]), .o_level(level[1]));

   // dut 2: 9 bit, div 2, CPOL 0, gap 2
   m_spi_fifo_tx #(.DATA_W(9), .FIFO_DEPTH(16), .CLK_DIV(2), .CPOL(1'b0), .GAP(2)) u_dut2 (
      .w_clk(clk), .w_rst_n(rst_n), .i_valid(valid[2]), .o_ready(ready[2]),
      .i_data(data), .i_dc(dc_in), .o_sda(sda[2]), .o_scl(scl[2]), .o_dc(dc_out[2]),
      .o_cs_n(cs_n[2]), .o_busy(busy[2]), .o_level(level[2]));

   function automatic logic cpol_of(input int g);
      return (g != 2);
   endfunction

   function automatic int dw_of(input int g);
      return (g == 2) ? 9 : 8;
   endfunction

   function automatic logic [8:0] mask_w(input int g, input logic [8:0] w);
      return (g == 2) ? w : {1'b0, w[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Monitor: a sampling edge is the ~CPOL -> CPOL transition of SCL.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (!rst_n) begin
            prev_scl[g] = cpol_of(g);
            mon_bits[g] = 0;
         end else begin
            if (prev_scl[g] != cpol_of(g) && scl[g] == cpol_of(g)) begin
               edge_cnt[g]++;
               check("cs_low_on_edge", cs_n[g], 0);
               if (mon_bits[g] == 0) mon_dc0[g] = dc_out[g];
               mon_sh[g] = {mon_sh[g][7:0], sda[g]};
               mon_bits[g]++;
               if (mon_bits[g] == dw_of(g)) begin
                  mon_bits[g] = 0;
                  words_done[g]++;
                  if (exp_q.size() == 0) begin
                     check("unexpected_word", 0, 1);
                  end else begin
                     mon_e = exp_q.pop_front();
                     check("word_dut", g, mon_e.dut);
                     check("word_data", mask_w(g, mon_sh[g]), mon_e.data);
                     check("word_dc_first", mon_dc0[g], mon_e.dc);
                     check("word_dc_last", dc_out[g], mon_e.dc);
                  end
               end
            end
            prev_scl[g] = scl[g];
         end
      end
   end

   task automatic push_word(input int g, input logic d, input logic [8:0] w);
      int waited = 0;
      valid[g] = 1'b1;
      data     = w;
      dc_in    = d;
      while (!ready[g] && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!ready[g]) check("push_timeout", ready[g], 1);
      else exp_q.push_back('{dut: 2'(g), dc: d, data: mask_w(g, w)});
      @(negedge clk);
      valid[g] = 1'b0;
   endtask

   task automatic wait_drain(input int g, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy[g]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_busy", busy[g], 0);
      check("drain_level", level[g], 0);
   endtask

   task automatic measure_burst(input int g, input int budget, output int low, output int edges);
      int w = 0;
      int e0;
      low   = 0;
      edges = 0;
      while (cs_n[g] !== 1'b0 && w < budget) begin
         @(negedge clk);
         w++;
      end
      if (cs_n[g] !== 1'b0) begin
         check("burst_start_timeout", cs_n[g], 0);
         return;
      end
      e0 = edge_cnt[g];
      while (cs_n[g] === 1'b0 && low < budget) begin
         low++;
         @(negedge clk);
      end
      edges = edge_cnt[g] - e0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int low, edges, accepted, wd0, e0, n, quiet;
      logic [8:0] w;
      valid = '0;
      data  = '0;
      dc_in = 1'b0;
      for (int g = 0; g < 3; g++) begin
         mon_bits[g]   = 0;
         words_done[g] = 0;
         edge_cnt[g]   = 0;
         mon_sh[g]     = '0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("rst_sda", sda[g], 1);
         check("rst_scl", scl[g], cpol_of(g));
         check("rst_dc", dc_out[g], 0);
         check("rst_cs_n", cs_n[g], 1);
         check("rst_busy", busy[g], 0);
         check("rst_level", level[g], 0);
         check("rst_ready", ready[g], 0);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++) check("ready_after_rst", ready[g], 1);

      // Single word 0xA5, dc=1: latency, burst length, edge count
      valid[0] = 1'b1;
      data     = 9'h0A5;
      dc_in    = 1'b1;
      exp_q.push_back('{dut: 2'd0, dc: 1'b1, data: 9'h0A5});
      @(negedge clk);
      valid[0] = 1'b0;
      check("t1_cs_after_push", cs_n[0], 1);
      check("t1_level_after_push", level[0], 1);
      check("t1_busy_after_push", busy[0], 1);
      @(negedge clk);
      check("t1_cs_at_load", cs_n[0], 0);
      check("t1_scl_phase_a", scl[0], 0);
      check("t1_dc", dc_out[0], 1);
      check("t1_sda_msb", sda[0], 1);
      check("t1_level_after_pop", level[0], 0);
      measure_burst(0, 200, low, edges);
      check("t1_cs_low_cycles", low, 17);
      check("t1_edges", edges, 8);
      check("t1_busy_end", busy[0], 0);
      check("t1_scl_idle", scl[0], 1);
      wait_drain(0, 200);

      // Randomised stream through dut 0
      for (int i = 0; i < 12; i++) begin
         push_word(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_drain(0, 2000);

      // Back-to-back with no gap: 0x2A (cmd) then 0x00 (data)
      push_word(1, 1'b0, 9'h02A);
      push_word(1, 1'b1, 9'h000);
      measure_burst(1, 1000, low, edges);
      check("t2_cs_low_cycles", low, 128);
      check("t2_edges", edges, 16);
      wait_drain(1, 500);

      // Fill dut 1 while holding valid, then keep pushing while full
      wd0      = words_done[1];
      accepted = 0;
      w        = 9'h010;
      valid[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         data  = w;
         dc_in = w[0];
         if (!ready[1]) break;
         exp_q.push_back('{dut: 2'd1, dc: w[0], data: w});
         accepted++;
         w = w + 9'd1;
         @(negedge clk);
      end
      check("t3_accepted", accepted, 17);
      check("t3_level_full", level[1], 16);
      check("t3_ready_full", ready[1], 0);
      check("t3_no_word_done", words_done[1] - wd0, 0);
      check("t3_cs_active", cs_n[1], 0);
      data  = 9'h0EE;
      dc_in = 1'b1;
      repeat (6) @(negedge clk);
      check("t6_level_hold", level[1], 16);
      check("t6_ready_hold", ready[1], 0);
      valid[1] = 1'b0;
      wait_drain(1, 17 * 70 + 200);

      // 9-bit words, CPOL=0, gap 2
      check("t5_scl_idle_low", scl[2], 0);
      push_word(2, 1'b1, 9'h1FF);
      measure_burst(2, 500, low, edges);
      check("t5_cs_low_cycles", low, 38);
      check("t5_edges", edges, 9);
      push_word(2, 1'b0, 9'h0A5);
      push_word(2, 1'b1, 9'h13C);
      measure_burst(2, 500, low, edges);
      check("t5_two_word_cycles", low, 76);
      check("t5_two_word_edges", edges, 18);
      wait_drain(2, 300);

      // Reset mid-word with 5 words queued
      valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data  = 9'h0C0 + 9'(i);
         dc_in = 1'b1;
         exp_q.push_back('{dut: 2'd0, dc: 1'b1, data: 9'h0C0 + 9'(i)});
         @(negedge clk);
      end
      valid[0] = 1'b0;
      e0 = edge_cnt[0];
      n  = 0;
      while (edge_cnt[0] - e0 < 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_mid_word", cs_n[0], 0);
      #2 rst_n = 1'b0;
      #1;
      check("t4_cs_n", cs_n[0], 1);
      check("t4_scl", scl[0], 1);
      check("t4_sda", sda[0], 1);
      check("t4_level", level[0], 0);
      check("t4_busy", busy[0], 0);
      check("t4_ready", ready[0], 0);
      exp_q.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("t4_ready_release", ready[0], 1);
      e0    = edge_cnt[0];
      quiet = 0;
      for (int i = 0; i < 40; i++) begin
         if (cs_n[0] !== 1'b1 || scl[0] !== 1'b1 || busy[0] !== 1'b0) quiet++;
         @(negedge clk);
      end
      check("t4_no_activity", quiet, 0);
      check("t4_no_edges", edge_cnt[0] - e0, 0);
      push_word(0, 1'b0, 9'h03C);
      wait_drain(0, 200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
